// File: rtl/arbiter_2to1.sv
// Two-requester round-robin arbiter driving a shared 2:1 data mux,
// with a single registered output beat under a valid/ready handshake.
module arbiter_2to1 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t state;
   logic   last;
   logic   load;
   logic   gnt_any;
   logic   gnt_idx;

   always_comb begin
      gnt_any = req0_valid | req1_valid;
      // On a tie the requester not served last wins; otherwise the lone valid one.
      gnt_idx = (req0_valid && req1_valid) ? ~last : req1_valid;
      load    = (state == EMPTY) || out_ready;
      sel     = gnt_any ? gnt_idx : last;
      // Readies are forced low while reset is held, even though load is high then.
      req0_ready = rst_n && load && gnt_any && !gnt_idx;
      req1_ready = rst_n && load && gnt_any &&  gnt_idx;
   end

   assign out_valid = (state == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         out_src  <= 1'b0;
         last     <= 1'b1;
      end else if (load) begin
         if (gnt_any) begin
            out_data <= gnt_idx ? req1_data : req0_data;
            out_src  <= gnt_idx;
            last     <= gnt_idx;
            state    <= FULL;
         end else begin
            state    <= EMPTY;
         end
      end
   end

endmodule

// File: doc/arbiter_2to1.md
# arbiter_2to1

Two-requester round-robin arbiter feeding a shared 2:1 datapath mux, with a registered output stage. Each requester presents a valid/data beat. The arbiter picks one per cycle, drives the mux select, and captures the selected beat into an output register with a valid/ready handshake toward the consumer. It is the controller that shares the catalog 2:1 mux between two producers.

## Interface
- WIDTH, 8, data width of each requester and of the output beat

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a beat
- req0_data  in  WIDTH  requester 0 beat
- req0_ready  out  1  requester 0 beat accepted this cycle
- req1_valid  in  1  requester 1 has a beat
- req1_data  in  WIDTH  requester 1 beat
- req1_ready  out  1  requester 1 beat accepted this cycle
- sel  out  1  combinational mux select this cycle (0 = req0, 1 = req1)
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered beat
- out_src  out  1  requester that produced out_data
- out_ready  in  1  consumer accepts the beat

## Operation
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Output-stage FSM states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: `load = !out_valid || out_ready`.
- Priority pointer `last`: the requester served most recently. Reset value is 1, so req0 wins the first tie.
- Grant, evaluated combinationally each cycle:
  - Only req0_valid set → grant 0.
  - Only req1_valid set → grant 1.
  - Both set → grant `!last`.
  - Neither set → no grant.
- `sel` = granted index. With no grant, `sel` holds `last`.
- `reqN_ready` = `load && grant==N`.
  - At most one ready is high per cycle.
  - Ready never rises without the matching valid.
- On a clock edge with `load` and a grant:
  - out_data ← selected data.
  - out_src ← grant.
  - out_valid ← 1.
  - last ← grant.
- On a clock edge with `load` and no grant: out_valid ← 0. out_data and out_src hold.
- On a clock edge without `load` (FULL and out_ready=0):
  - All outputs hold.
  - Both readies are 0.
  - `last` holds.
- Transitions:
  - EMPTY→FULL on grant.
  - FULL→FULL on (out_ready && grant) or !out_ready.
  - FULL→EMPTY on out_ready && no grant.
- Requesters keep valid and data stable until their ready is seen high. The arbiter does not check this.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, last=1.
- While rst_n is low: req0_ready=0 and req1_ready=0.
- Assertion of rst_n mid-transfer drops any beat held in the output register immediately (asynchronous).
- Latency: a beat accepted at edge N appears on out_data/out_valid right after edge N. The consumer can take it at edge N+1.
- Throughput: one beat per cycle when out_ready is held high. There is no bubble between back-to-back beats.
- Fairness with both valid continuously: grants alternate 0,1,0,1…, and the pointer advances only on an actual transfer. Neither requester waits more than one transfer.
- Output stall: `last` is frozen while stalled. After release, arbitration resumes from the frozen pointer.
- Paths from reqN_valid and out_ready to reqN_ready and sel are combinational.
- All other outputs are registered.

## Test plan
1. Reset, then assert req0_valid=1 with data 0x11 and req1_valid=0, out_ready=1.
   - req0_ready=1 in the same cycle.
   - Next cycle: out_valid=1, out_data=0x11, out_src=0.
2. Both requesters continuously valid (req0 0xA0.., req1 0xB0..), out_ready=1 for 6 cycles.
   - out_src sequence 0,1,0,1,0,1.
   - One beat per cycle.
   - First beat is from req0.
3. Output full, out_ready=0 for 3 cycles, both valid.
   - Both readies are 0.
   - out_data holds its value.
   - After out_ready=1, the grant goes to the requester not served last.
4. Only req1 valid for 3 beats, then both valid.
   - req1 served 3 times.
   - On the next tie, req0 is granted (last=1).
5. Mid-stream, drive rst_n low asynchronously between edges.
   - out_valid=0, out_data=0, out_src=0 immediately, and both readies are 0.
   - After release, the first tie goes to req0.
6. Single beat accepted, then no valid inputs with out_ready=1.
   - out_valid is high for exactly one cycle, then 0.
   - out_data retains the last value.
